// File: rtl/divider_6bit.sv
// Sequential unsigned restoring divider: 2N-bit dividend / N-bit divisor,
// one quotient bit per clock, with divide-by-zero short-circuit.
module divider_6bit #(
  parameter int N = 6
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           start,
  input  logic [2*N-1:0] A,
  input  logic [N-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic           dz,
  output logic [2*N-1:0] Q,
  output logic [N-1:0]   REM
);

  localparam int QW = 2 * N;
  localparam int CW = $clog2(QW);
  localparam logic [CW-1:0] LAST = CW'(QW - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state, state_nxt;
  logic [QW-1:0]  dvd, quo;
  logic [N-1:0]   dvs, rem;
  logic [CW-1:0]  cnt;
  logic           dz_q;

  logic [N:0]     trial;
  logic [N-1:0]   diff;
  logic           qbit;

  // Partial remainder stays below the divisor, so the N-bit difference of the
  // low bits equals the full (N+1)-bit subtraction whenever qbit is set.
  assign trial = {rem, dvd[QW-1]};
  assign qbit  = (trial >= {1'b0, dvs});
  assign diff  = trial[N-1:0] - dvs;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (B == '0) ? DONE : CALC;
      CALC: if (cnt == LAST) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dvd  <= '0;
      dvs  <= '0;
      quo  <= '0;
      rem  <= '0;
      cnt  <= '0;
      dz_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          dz_q <= (B == '0);
          dvd  <= A;
          dvs  <= B;
          rem  <= '0;
          cnt  <= '0;
          quo  <= (B == '0) ? '1 : '0;
        end
        CALC: begin
          rem <= qbit ? diff : trial[N-1:0];
          quo <= {quo[QW-2:0], qbit};
          dvd <= {dvd[QW-2:0], 1'b0};
          cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);
  assign dz   = dz_q;
  assign Q    = quo;
  assign REM  = rem;

endmodule
